// File: rtl/exc_pkg.sv
// Shared types and constants for the exception-entry sequencer.
// Cause codes double as the exception-vector mux selector encoding.
package exc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SEL,
        WAIT,
        LOAD,
        DONE
    } exc_state_t;

    localparam logic [1:0] EXC_NONE   = 2'd0;
    localparam logic [1:0] EXC_OPCODE = 2'd1;
    localparam logic [1:0] EXC_OVF    = 2'd2;
    localparam logic [1:0] EXC_DIV0   = 2'd3;

    localparam logic [7:0] VEC_OPCODE = 8'd253;
    localparam logic [7:0] VEC_OVF    = 8'd254;
    localparam logic [7:0] VEC_DIV0   = 8'd255;

    localparam logic [31:0] PC_DEC_DEF = 32'd4;

    // Fixed priority: opcode > overflow > divide-by-zero.
    function automatic logic [1:0] pick_cause(input logic op, input logic ovf, input logic div);
        if (op)       return EXC_OPCODE;
        else if (ovf) return EXC_OVF;
        else if (div) return EXC_DIV0;
        else          return EXC_NONE;
    endfunction

endpackage

// File: rtl/exc_ctrl.sv
// Exception-entry sequencer: pick cause, save EPC, fetch handler byte via vector mux, load PC.
// Optional EXC_CAUSE_REG_EN exposes the last serviced cause on cause_out.
module exc_ctrl
    import exc_pkg::*;
#(
    parameter int          MEM_WAIT = 1,
    parameter logic [31:0] PC_DEC   = PC_DEC_DEF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_valid,
    input  logic        exc_opcode,
    input  logic        exc_overflow,
    input  logic        exc_divzero,
    input  logic [31:0] pc_in,
    input  logic [31:0] mem_data_in,
    output logic [3:0]  exc_sel,
    output logic        mem_read,
    output logic        pc_write,
    output logic [31:0] pc_exc_value,
    output logic [31:0] epc,
    output logic        busy,
    output logic        done
`ifdef EXC_CAUSE_REG_EN
    ,
    output logic [1:0]  cause_out
`endif
);

    exc_state_t  r_state;
    exc_state_t  w_next;
    logic [1:0]  r_cause;
    logic [3:0]  r_cnt;
    logic [31:0] r_epc;
    logic [1:0]  w_cause;
    logic        w_take;
    logic        w_unused;

    assign w_cause  = pick_cause(exc_opcode, exc_overflow, exc_divzero);
    assign w_take   = exc_valid && (w_cause != EXC_NONE);
    assign epc      = r_epc;
    assign w_unused = ^mem_data_in[31:8];

`ifdef EXC_CAUSE_REG_EN
    assign cause_out = r_cause;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cause <= EXC_NONE;
            r_cnt   <= 4'd0;
            r_epc   <= 32'd0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && w_take) begin
                r_cause <= w_cause;
                r_epc   <= pc_in - PC_DEC;
            end
            if (r_state == SEL)
                r_cnt <= 4'(MEM_WAIT);
            else if (r_state == WAIT)
                r_cnt <= r_cnt - 4'd1;
        end
    end

    // Outputs are pure functions of state so reset clears them immediately.
    always_comb begin
        w_next       = r_state;
        exc_sel      = 4'd0;
        mem_read     = 1'b0;
        pc_write     = 1'b0;
        pc_exc_value = 32'd0;
        busy         = 1'b1;
        done         = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_take) w_next = SEL;
            end
            SEL: begin
                exc_sel  = {2'b00, r_cause};
                mem_read = 1'b1;
                w_next   = (MEM_WAIT == 0) ? LOAD : WAIT;
            end
            WAIT: begin
                exc_sel  = {2'b00, r_cause};
                mem_read = 1'b1;
                if (r_cnt <= 4'd1) w_next = LOAD;
            end
            LOAD: begin
                exc_sel      = {2'b00, r_cause};
                pc_write     = 1'b1;
                pc_exc_value = {24'd0, mem_data_in[7:0]};
                w_next       = DONE;
            end
            DONE: begin
                done   = 1'b1;
                w_next = IDLE;
            end
            default: begin
                busy   = 1'b0;
                w_next = IDLE;
            end
        endcase
    end

endmodule
